// File: rtl/mux_nx_reg_rr.sv
// mux_nx_reg_rr: N-channel selector with a registered, flow-controlled output.
// A channel is chosen either by an external index (fixed mode) or by a
// round-robin scan over channels with pending data. The chosen word lands in
// a single-entry output register that can be refilled on the cycle it drains.
module mux_nx_reg_rr #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       InValid,
  output logic [CHANNELS-1:0]       InReady,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Sel,
  output logic [WIDTH-1:0]          S,
  output logic                      SValid,
  output logic [SEL_W-1:0]          SChan,
  input  logic                      SReady
);

  logic             load;
  logic             xfer;
  logic [SEL_W-1:0] ptr;
  logic             hit_hi;
  logic             hit_any;
  logic [SEL_W-1:0] idx_hi;
  logic [SEL_W-1:0] idx_any;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [SEL_W-1:0] ptr_nxt;

  // The output register can take a new word when empty or when it drains this cycle.
  assign load = !SValid || SReady;
  assign xfer = |(InValid & InReady);

  // Round-robin scan as two priority searches: lowest valid channel at or
  // above ptr, falling back to the lowest valid channel overall (the wrap).
  always_comb begin
    hit_hi  = 1'b0;
    hit_any = 1'b0;
    idx_hi  = '0;
    idx_any = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (InValid[i]) begin
        hit_any = 1'b1;
        idx_any = SEL_W'(i);
        if (SEL_W'(i) >= ptr) begin
          hit_hi = 1'b1;
          idx_hi = SEL_W'(i);
        end
      end
    end
  end

  // Pick the granted channel; out-of-range Sel values match no channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!Mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (Sel == SEL_W'(i)) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else if (hit_hi) begin
      grant_vld = 1'b1;
      grant_idx = idx_hi;
    end else if (hit_any) begin
      grant_vld = 1'b1;
      grant_idx = idx_any;
    end
  end

  // Route the granted channel's data and its successor index for the pointer.
  always_comb begin
    grant_data = '0;
    ptr_nxt    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = D[i*WIDTH +: WIDTH];
        ptr_nxt    = (i == CHANNELS - 1) ? '0 : SEL_W'(i + 1);
      end
    end
  end

  // Only the granted channel sees ready, and only when the output can load.
  always_comb begin
    InReady = '0;
    if (grant_vld && load) begin
      InReady[grant_idx] = 1'b1;
    end
  end

  // Output register and round-robin pointer; a refill on a drain cycle keeps SValid high.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      S      <= '0;
      SValid <= 1'b0;
      SChan  <= '0;
      ptr    <= '0;
    end else begin
      if (xfer) begin
        S      <= grant_data;
        SChan  <= grant_idx;
        SValid <= 1'b1;
        if (Mode) begin
          ptr <= ptr_nxt;
        end
      end else if (SValid && SReady) begin
        SValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx_reg_rr.sv
// Bench for mux_nx_reg_rr: a 4-channel and a 3-channel instance run side by
// side against a transaction-level model of the selector.
module tb_mux_nx_reg_rr;

  logic        Clk;
  logic        Rst;

  logic [15:0] d4;
  logic [3:0]  v4;
  logic [3:0]  rdy4;
  logic        mode4;
  logic [1:0]  sel4;
  logic [3:0]  s4;
  logic        sv4;
  logic [1:0]  sc4;
  logic        sr4;

  logic [11:0] d3;
  logic [2:0]  v3;
  logic [2:0]  rdy3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [3:0]  s3;
  logic        sv3;
  logic [1:0]  sc3;
  logic        sr3;

  int checks   = 0;
  int failures = 0;

  // Model state per instance: [0] = 4 channels, [1] = 3 channels.
  int ms[2];
  int mv[2];
  int mc[2];
  int mp[2];

  mux_nx_reg_rr #(.WIDTH(4), .CHANNELS(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .D(d4), .InValid(v4), .InReady(rdy4),
    .Mode(mode4), .Sel(sel4), .S(s4), .SValid(sv4), .SChan(sc4), .SReady(sr4)
  );

  mux_nx_reg_rr #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .D(d3), .InValid(v3), .InReady(rdy3),
    .Mode(mode3), .Sel(sel3), .S(s3), .SValid(sv3), .SChan(sc3), .SReady(sr3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Granted channel by the selection rules, or -1 when nothing is granted.
  function automatic int model_grant(int n, logic mode, int sel, logic [15:0] valid, int ptr);
    if (!mode) return (sel < n) ? sel : -1;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (ptr + k) % n;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      ms[j] = 0; mv[j] = 0; mc[j] = 0; mp[j] = 0;
    end
  endtask

  // Called just after a rising edge with inputs already driven: check, clock, advance model.
  task automatic tick();
    int g4, g3;
    logic ld4, ld3;
    logic [3:0] e4;
    logic [2:0] e3;
    #1;
    ld4 = (mv[0] == 0) || sr4;
    ld3 = (mv[1] == 0) || sr3;
    g4 = model_grant(4, mode4, int'(sel4), {12'b0, v4}, mp[0]);
    g3 = model_grant(3, mode3, int'(sel3), {13'b0, v3}, mp[1]);
    e4 = (g4 >= 0 && ld4) ? 4'(1 << g4) : 4'b0;
    e3 = (g3 >= 0 && ld3) ? 3'(1 << g3) : 3'b0;
    chk("rdy4", 32'(rdy4), 32'(e4));
    chk("s4",   32'(s4),   ms[0]);
    chk("sv4",  32'(sv4),  mv[0]);
    chk("sc4",  32'(sc4),  mc[0]);
    chk("rdy3", 32'(rdy3), 32'(e3));
    chk("s3",   32'(s3),   ms[1]);
    chk("sv3",  32'(sv3),  mv[1]);
    chk("sc3",  32'(sc3),  mc[1]);
    @(posedge Clk);
    if (g4 >= 0 && ld4 && v4[g4]) begin
      ms[0] = int'((d4 >> (4 * g4)) & 16'hF);
      mc[0] = g4;
      mv[0] = 1;
      if (mode4) mp[0] = (g4 + 1) % 4;
    end else if (mv[0] != 0 && sr4) begin
      mv[0] = 0;
    end
    if (g3 >= 0 && ld3 && v3[g3]) begin
      ms[1] = int'((d3 >> (4 * g3)) & 12'hF);
      mc[1] = g3;
      mv[1] = 1;
      if (mode3) mp[1] = (g3 + 1) % 3;
    end else if (mv[1] != 0 && sr3) begin
      mv[1] = 0;
    end
    #1;
  endtask

  initial begin
    int rr_exp[6];
    rr_exp = '{0, 1, 3, 0, 1, 3};
    Rst = 1'b1;
    d4 = '0; v4 = '0; mode4 = 1'b0; sel4 = '0; sr4 = 1'b1;
    d3 = '0; v3 = '0; mode3 = 1'b0; sel3 = '0; sr3 = 1'b1;
    model_reset();

    // Reset state
    #12;
    chk("rst_s4", 32'(s4), 0);
    chk("rst_sv4", 32'(sv4), 0);
    chk("rst_sc4", 32'(sc4), 0);
    chk("rst_sv3", 32'(sv3), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Fixed mode, Sel=2
    mode4 = 1'b0; sel4 = 2'd2; v4 = 4'b1111; d4 = 16'h3951; sr4 = 1'b1;
    #1;
    chk("fix_rdy", 32'(rdy4), 32'h4);
    tick();
    chk("fix_s", 32'(s4), 32'h9);
    chk("fix_sc", 32'(sc4), 2);
    tick();
    chk("fix_sv_cont", 32'(sv4), 1);

    // Round-robin fairness with channel 2 idle
    mode4 = 1'b1; v4 = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_seq", 32'(sc4), rr_exp[k]);
    end

    // Backpressure: word held, no ready, producer data change not sampled
    mode4 = 1'b0; sel4 = 2'd1; v4 = 4'b1111; d4 = 16'h0070;
    tick();
    chk("bp_load", 32'(s4), 32'h7);
    sr4 = 1'b0; d4 = 16'h00C0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", 32'(rdy4), 0);
      tick();
      chk("bp_s", 32'(s4), 32'h7);
      chk("bp_sv", 32'(sv4), 1);
    end
    sr4 = 1'b1;
    tick();
    chk("bp_refill_s", 32'(s4), 32'hC);
    chk("bp_refill_sv", 32'(sv4), 1);

    // Out-of-range select on the 3-channel instance
    v3 = 3'b000; sr3 = 1'b1;
    tick();
    mode3 = 1'b0; sel3 = 2'd3; v3 = 3'b111; d3 = 12'h4B2;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("oor_rdy", 32'(rdy3), 0);
      tick();
      chk("oor_sv", 32'(sv3), 0);
    end
    sel3 = 2'd1;
    tick();
    chk("oor_sc", 32'(sc3), 1);
    chk("oor_s", 32'(s3), 32'hB);
    v3 = 3'b000;

    // Mode switch: pointer parked at 2 survives fixed-mode transfers
    mode4 = 1'b1; v4 = 4'b0010; d4 = 16'h5678;
    tick();
    chk("ms_rr", 32'(sc4), 1);
    mode4 = 1'b0; sel4 = 2'd0; v4 = 4'b1111;
    tick();
    tick();
    chk("ms_fix", 32'(sc4), 0);
    mode4 = 1'b1;
    tick();
    chk("ms_back", 32'(sc4), 2);

    // Asynchronous reset mid-stream while S=A
    mode4 = 1'b0; sel4 = 2'd0; v4 = 4'b0001; d4 = 16'h000A;
    tick();
    chk("pre_rst_s", 32'(s4), 32'hA);
    #2;
    Rst = 1'b1;
    #1;
    chk("arst_s", 32'(s4), 0);
    chk("arst_sv", 32'(sv4), 0);
    chk("arst_sc", 32'(sc4), 0);
    model_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    mode4 = 1'b1; v4 = 4'b1010; d4 = 16'h1234;
    tick();
    chk("cold_sc", 32'(sc4), 1);
    chk("cold_s", 32'(s4), 32'h3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      d4 = 16'($urandom);
      v4 = 4'($urandom);
      sel4 = 2'($urandom);
      sr4 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode4 = ~mode4;
      d3 = 12'($urandom);
      v3 = 3'($urandom);
      sel3 = 2'($urandom);
      sr3 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode3 = ~mode3;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_nx_reg_rr.md
Name: mux_nx_reg_rr

Overview:
Parametrised N-channel, W-bit selector with a registered output stage and valid/ready handshakes on every channel and on the output.
It has two selection modes: fixed (external Sel, like a classic N:1 mux) and round-robin arbitration across channels with pending data.
It sits between several producers (operand/result sources) and a single consumer, such as a display or result register.
It replaces per-bit combinational muxing where a registered, flow-controlled path is needed.

Parameters:
WIDTH, 4, data width of each channel and of the output
CHANNELS, 4, number of input channels; legal range 2..16
SEL_W, derived localparam = clog2(CHANNELS), not overridable; width of Sel and SChan

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous, active-high reset
D  input  CHANNELS*WIDTH  flattened channel data; channel i = D[i*WIDTH +: WIDTH]
InValid  input  CHANNELS  per-channel data-valid
InReady  output  CHANNELS  per-channel accept; combinational
Mode  input  1  0 = fixed select, 1 = round-robin
Sel  input  SEL_W  channel index used in fixed mode
S  output  WIDTH  registered selected data
SValid  output  1  S holds an unconsumed word
SChan  output  SEL_W  index of the channel that produced S
SReady  input  1  consumer accepts S

Behaviour:
- Reset (async, Rst=1): S=0, SValid=0, SChan=0, round-robin pointer ptr=0. Any held word is discarded. Release is synchronous to the next Clk edge.
- Load enable: load = (!SValid) || SReady. The output register is single-entry with no skid buffer.
- Grant, fixed mode (Mode=0):
  - Candidate is Sel.
  - If Sel >= CHANNELS, there is no grant and all InReady = 0.
  - InValid of other channels is ignored.
- Grant, round-robin mode (Mode=1):
  - Candidate is the first i with InValid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo CHANNELS.
  - If no InValid bit is set, there is no grant.
- Handshake outputs:
  - InReady[g] = load for the granted channel g only. All other bits are 0.
  - InReady never depends on InValid of a non-candidate channel in fixed mode.
- Channel transfer: occurs at the Clk edge where InValid[g] && InReady[g]. On that edge: S <= channel g data, SChan <= g, SValid <= 1.
- Output transfer: occurs at the edge where SValid && SReady.
  - If a channel transfer happens on the same edge, the new word replaces the old one and SValid stays 1. This gives full throughput of 1 word/cycle.
  - If there is no channel transfer, SValid <= 0, and S and SChan hold their last value.
- Stall: when SValid=1 and SReady=0, S, SChan and SValid are held stable and all InReady = 0.
- Latency: 1 cycle from channel transfer to SValid/S.
- Pointer update: ptr <= (g+1) mod CHANNELS only on a channel transfer in round-robin mode. The wrap from CHANNELS-1 goes to 0.
  - ptr is unchanged in fixed mode and unchanged across Mode switches.
- Mode or Sel changes take effect combinationally on the next grant evaluation. A word already in S is unaffected.
- No data reordering within a channel. Producer-side data is sampled only on its transfer edge.
- Non-power-of-two CHANNELS: unused index values are never granted and never appear on SChan.

Test Plan:
- Reset: assert Rst mid-stream while SValid=1 and S=4'hA -> S=0, SValid=0, SChan=0 immediately, without waiting for a Clk edge; the first transfer after release behaves as from cold start.
- Fixed mode: Mode=0, Sel=2, InValid=4'b1111, D channels = {3:4'h3, 2:4'h9, 1:4'h5, 0:4'h1}, SReady=1 -> InReady=4'b0100; S=4'h9, SChan=2 one cycle later; continuous SValid=1.
- Round-robin fairness: Mode=1, InValid=4'b1011 held, SReady=1 -> SChan sequence 0,1,3,0,1,3; channel 2 never granted; ptr wraps 3->0.
- Backpressure: SValid=1, S=4'h7, SReady=0 for 3 cycles with inputs valid -> S/SChan stable, InReady=0; on SReady=1 the next word loads on the same edge with SValid staying 1.
- Out-of-range select: CHANNELS=3, Mode=0, Sel=3, InValid=3'b111 -> InReady=0 and SValid never rises; then Sel=1 -> channel 1 is transferred next cycle.
- Mode switch: run round-robin until ptr=2, switch to fixed Sel=0 for 2 transfers, switch back -> first round-robin grant starts the scan at channel 2.
